// File: rtl/y86_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_loader_pkg
// Description : Shared types and constants for the y86 IRAM image loader.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_loader_pkg;

    // Loader frame-parsing states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } loader_state_t;

    // Default frame start marker
    localparam logic [7:0] C_SYNC_BYTE = 8'h86;

    // Each header field (base address, length) is this many bytes, little-endian
    localparam int C_HDR_BYTES = 4;
    localparam int C_HDR_W     = C_HDR_BYTES * 8;

endpackage
`default_nettype wire

// File: rtl/y86_loader_hdr_shift.sv
`default_nettype none
// ============================================================================
// Module      : y86_loader_hdr_shift
// Description : Little-endian header field assembler. Each shifted byte enters
//               at the top, so after C_HDR_BYTES shifts the first byte sits in
//               bits [7:0]. o_word already includes the byte being shifted, so
//               the parent can act on the complete field in the same cycle
//               its last byte is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_loader_hdr_shift (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_shift_en,
    input  logic [7:0]                         i_byte,
    output logic [y86_loader_pkg::C_HDR_W-1:0] o_word
);
    import y86_loader_pkg::*;

    logic [C_HDR_W-1:0] r_field;

    assign o_word = {i_byte, r_field[C_HDR_W-1:8]};

    // Shift register holding the bytes received so far for the current field
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_field <= '0;
        end else if (i_shift_en) begin
            r_field <= o_word;
        end
    end

endmodule
`default_nettype wire

// File: rtl/y86_iram_loader.sv
`default_nettype none
// ============================================================================
// Module      : y86_iram_loader
// Description : Parses a framed byte stream (sync, base, length, payload,
//               optional checksum) and writes the payload into the y86
//               instruction RAM, holding the CPU in reset until a complete,
//               valid image has landed.
//               Optional feature macro: Y86_LOADER_CHECKSUM_EN
// Revision    : 1.0 - initial release
// ============================================================================
module y86_iram_loader #(
    parameter int         ADDR_W    = 32,
    parameter int         MEM_BYTES = 4096,
    parameter logic [7:0] SYNC_BYTE = y86_loader_pkg::C_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              rearm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] bytes_written
);
    import y86_loader_pkg::*;

    localparam logic [ADDR_W:0] C_MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
    localparam int              C_CNT_W     = $clog2(C_HDR_BYTES);

`ifdef Y86_LOADER_CHECKSUM_EN
    localparam loader_state_t C_AFTER_PAYLOAD = ST_CSUM;
`else
    localparam loader_state_t C_AFTER_PAYLOAD = ST_DONE;
`endif

    loader_state_t       r_state;
    loader_state_t       w_state_next;

    logic                w_accept;
    logic                w_is_sync;
    logic [C_CNT_W-1:0]  r_hdr_cnt;
    logic                w_hdr_last;
    logic                w_hdr_shift_en;
    logic [C_HDR_W-1:0]  w_hdr_word;
    logic [ADDR_W-1:0]   w_field;

    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_len;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W:0]     w_end_sum;
    logic                w_len_bad;
    logic                w_pay_last;

    logic                r_pend_valid;
    logic [ADDR_W-1:0]   r_pend_addr;
    logic [7:0]          r_pend_data;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [7:0]          r_wr_data;
    logic [ADDR_W-1:0]   r_bytes_written;
    logic                r_done;
    logic                w_rearm_take;

`ifdef Y86_LOADER_CHECKSUM_EN
    logic [7:0]          r_csum;
    logic [7:0]          w_csum_total;
    assign w_csum_total = r_csum + in_data;
`endif

    assign in_ready   = (r_state == ST_IDLE) || (r_state == ST_ADDR) || (r_state == ST_LEN)
                     || (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
    assign w_accept   = in_valid && in_ready;
    assign w_is_sync  = (r_state == ST_IDLE) && w_accept && (in_data == SYNC_BYTE);
    assign w_hdr_last = (r_hdr_cnt == C_CNT_W'(C_HDR_BYTES - 1));
    assign w_hdr_shift_en = w_accept && ((r_state == ST_ADDR) || (r_state == ST_LEN));
    assign w_field    = ADDR_W'(w_hdr_word);

    // Range check runs one bit wider so base+len cannot wrap past zero
    assign w_end_sum  = {1'b0, r_base} + {1'b0, w_field};
    assign w_len_bad  = ({1'b0, w_field} > C_MEM_LIMIT) || (w_end_sum > C_MEM_LIMIT);
    assign w_pay_last = (r_idx == (r_len - ADDR_W'(1)));

    assign w_rearm_take = rearm && ((r_state == ST_DONE) || (r_state == ST_ERROR));

    assign wr_en         = r_wr_en;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign bytes_written = r_bytes_written;
    assign done          = r_done;
    assign cpu_hold      = ~r_done;
    assign error         = (r_state == ST_ERROR);

    y86_loader_hdr_shift u_hdr_shift (
        .clk        (clk),
        .reset      (reset),
        .i_shift_en (w_hdr_shift_en),
        .i_byte     (in_data),
        .o_word     (w_hdr_word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; every transition is qualified by an accepted byte or rearm
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_is_sync) begin
                    w_state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_accept && w_hdr_last) begin
                    w_state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_accept && w_hdr_last) begin
                    if (w_len_bad) begin
                        w_state_next = ST_ERROR;
                    end else if (w_field == '0) begin
                        w_state_next = C_AFTER_PAYLOAD;
                    end else begin
                        w_state_next = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_accept && w_pay_last) begin
                    w_state_next = C_AFTER_PAYLOAD;
                end
            end
            ST_CSUM: begin
`ifdef Y86_LOADER_CHECKSUM_EN
                if (w_accept) begin
                    w_state_next = (w_csum_total == 8'h00) ? ST_DONE : ST_ERROR;
                end
`else
                w_state_next = ST_IDLE;
`endif
            end
            ST_DONE, ST_ERROR: begin
                if (rearm) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Header byte counter and latched base/length fields
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hdr_cnt <= '0;
            r_base    <= '0;
            r_len     <= '0;
        end else if (w_is_sync) begin
            r_hdr_cnt <= '0;
        end else if (w_hdr_shift_en) begin
            r_hdr_cnt <= r_hdr_cnt + C_CNT_W'(1);
            if (w_hdr_last && (r_state == ST_ADDR)) begin
                r_base <= w_field;
            end
            if (w_hdr_last && (r_state == ST_LEN)) begin
                r_len <= w_field;
            end
        end
    end

    // Payload index and first write stage (captures the accepted byte)
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
        end else begin
            r_pend_valid <= 1'b0;
            if (w_is_sync) begin
                r_idx <= '0;
            end else if (w_accept && (r_state == ST_PAYLOAD)) begin
                r_idx        <= r_idx + ADDR_W'(1);
                r_pend_valid <= 1'b1;
                r_pend_addr  <= r_base + r_idx;
                r_pend_data  <= in_data;
            end
        end
    end

    // Second write stage drives the IRAM port; written-byte count tracks each strobe
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_en         <= 1'b0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
            r_bytes_written <= '0;
        end else begin
            r_wr_en <= r_pend_valid;
            if (r_pend_valid) begin
                r_wr_addr <= r_pend_addr;
                r_wr_data <= r_pend_data;
            end
            if (w_rearm_take || w_is_sync) begin
                r_bytes_written <= '0;
            end else if (r_pend_valid) begin
                r_bytes_written <= r_bytes_written + ADDR_W'(1);
            end
        end
    end

    // done rises only once the final payload write has left the pipeline
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE) && (w_state_next == ST_DONE) && !r_pend_valid;
        end
    end

`ifdef Y86_LOADER_CHECKSUM_EN
    // Running mod-256 payload sum for the trailing checksum byte
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_csum <= '0;
        end else if (w_is_sync) begin
            r_csum <= '0;
        end else if (w_accept && (r_state == ST_PAYLOAD)) begin
            r_csum <= w_csum_total;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_y86_iram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_y86_iram_loader
// Description : Self-checking bench for y86_iram_loader. Expected IRAM writes
//               are queued as payload bytes are driven and compared as the
//               write strobe appears. Optional macro: Y86_LOADER_CHECKSUM_EN
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_y86_iram_loader;

    localparam int ADDR_W    = 32;
    localparam int MEM_BYTES = 4096;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              rearm = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] bytes_written;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] pay[$];
    int         wr_cycs[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_wr = 0;
    int         cyc = 0;
    bit         done_wr_overlap = 1'b0;
`ifdef Y86_LOADER_CHECKSUM_EN
    logic [7:0] pay_sum;
`endif

    y86_iram_loader #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES),
        .SYNC_BYTE (8'h86)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rearm         (rearm),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .error         (error),
        .bytes_written (bytes_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Write monitor: pops the scoreboard on every strobe
    always @(negedge clk) begin
        if (reset && wr_en) begin
            n_wr++;
            wr_cycs.push_back(cyc);
            if (done) done_wr_overlap = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            check("send_timeout", 32'd1, 32'd0);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_header(input logic [31:0] base, input logic [31:0] len);
        send_byte(8'h86);
        for (int i = 0; i < 4; i++) send_byte(base[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
    endtask

`ifdef Y86_LOADER_CHECKSUM_EN
    task automatic send_csum(input logic [7:0] adj);
        send_byte(8'h00 - pay_sum + adj);
    endtask
`endif

    // Payload bytes come from pay[]; gaps inserts an idle cycle before each byte
    task automatic send_body(input logic [31:0] base, input bit gaps);
`ifdef Y86_LOADER_CHECKSUM_EN
        pay_sum = 8'h00;
`endif
        for (int i = 0; i < pay.size(); i++) begin
            if (gaps) @(negedge clk);
            exp_q.push_back('{addr: base + i, data: pay[i]});
`ifdef Y86_LOADER_CHECKSUM_EN
            pay_sum = pay_sum + pay[i];
`endif
            send_byte(pay[i]);
        end
    endtask

    task automatic send_frame(input logic [31:0] base, input bit gaps);
        send_header(base, pay.size());
        send_body(base, gaps);
`ifdef Y86_LOADER_CHECKSUM_EN
        send_csum(8'h00);
`endif
    endtask

    task automatic wait_end(input string tag);
        int g;
        g = 0;
        while (!done && !error && g < 40) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_terminated"}, {31'd0, (g < 40)}, 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic do_rearm();
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rearm    = 1'b0;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        check({tag, "_wr_addr"}, wr_addr, 32'd0);
        check({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_bytes_written"}, bytes_written, 32'd0);
    endtask

    initial begin
        int wr0;
        @(negedge clk);
        do_reset();
        check_reset_vals("rst");

        // Basic 3-byte frame at 0x100, continuous valid
        wr_cycs.delete();
        pay = '{8'h30, 8'hF0, 8'h0A};
        send_frame(32'h100, 1'b0);
        wait_end("f1");
        check("f1_done", {31'd0, done}, 32'd1);
        check("f1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("f1_bytes_written", bytes_written, 32'd3);
        check("f1_in_ready", {31'd0, in_ready}, 32'd0);
        check("f1_nwr", wr_cycs.size(), 32'd3);
        if (wr_cycs.size() == 3) begin
            check("f1_b2b_0", wr_cycs[1] - wr_cycs[0], 32'd1);
            check("f1_b2b_1", wr_cycs[2] - wr_cycs[1], 32'd1);
        end
        do_rearm();
        check("rearm_done", {31'd0, done}, 32'd0);
        check("rearm_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rearm_bytes_written", bytes_written, 32'd0);
        check("rearm_in_ready", {31'd0, in_ready}, 32'd1);

        // Garbage before sync, 1-byte frame at base 0
        send_byte(8'h11);
        send_byte(8'h22);
        pay = '{8'h5A};
        send_frame(32'h0, 1'b0);
        wait_end("f2");
        check("f2_done", {31'd0, done}, 32'd1);
        check("f2_bytes_written", bytes_written, 32'd1);
        do_rearm();

        // base+len past the end of memory
        wr0 = n_wr;
        send_header(32'hFFE, 32'd4);
        check("ovf_error", {31'd0, error}, 32'd1);
        check("ovf_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("ovf_in_ready", {31'd0, in_ready}, 32'd0);
        in_data  = 8'h86;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("ovf_still_error", {31'd0, error}, 32'd1);
        check("ovf_no_writes", n_wr - wr0, 32'd0);
        do_rearm();
        check("ovf_rearm_error", {31'd0, error}, 32'd0);

        // len alone larger than memory
        send_header(32'h0, 32'h1001);
        check("biglen_error", {31'd0, error}, 32'd1);
        do_rearm();

        // base near 2^32 must not wrap into a legal range
        send_header(32'hFFFF_FFFF, 32'd2);
        check("wrap_error", {31'd0, error}, 32'd1);
        do_rearm();

        // Frame exactly filling the top of memory
        pay = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_frame(32'hFFC, 1'b0);
        wait_end("top");
        check("top_done", {31'd0, done}, 32'd1);
        check("top_error", {31'd0, error}, 32'd0);
        do_rearm();

        // Zero-length frame
        wr0 = n_wr;
        pay.delete();
        send_frame(32'h10, 1'b0);
        wait_end("zero");
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_no_writes", n_wr - wr0, 32'd0);
        do_rearm();

        // Valid toggling during payload
        pay = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
        send_frame(32'h20, 1'b1);
        wait_end("gap");
        check("gap_bytes_written", bytes_written, 32'd5);
        do_rearm();

        // Reset in the middle of a payload, then a fresh frame
        send_header(32'h40, 32'd4);
        pay = '{8'hEE, 8'hDD};
        send_body(32'h40, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_bytes_written", bytes_written, 32'd2);
        do_reset();
        check_reset_vals("mid_rst");
        pay = '{8'h9C, 8'h3E};
        send_frame(32'h80, 1'b0);
        wait_end("post_rst");
        check("post_rst_done", {31'd0, done}, 32'd1);
        check("post_rst_bytes_written", bytes_written, 32'd2);
        do_rearm();

`ifdef Y86_LOADER_CHECKSUM_EN
        // Checksum good then bad
        pay = '{8'h01, 8'h02};
        send_frame(32'h200, 1'b0);
        wait_end("csum_ok");
        check("csum_ok_done", {31'd0, done}, 32'd1);
        check("csum_ok_error", {31'd0, error}, 32'd0);
        do_rearm();
        send_header(32'h200, 32'd2);
        send_body(32'h200, 1'b0);
        send_csum(8'h01);
        wait_end("csum_bad");
        check("csum_bad_error", {31'd0, error}, 32'd1);
        check("csum_bad_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        do_rearm();
        check("csum_rearm_error", {31'd0, error}, 32'd0);
`endif

        check("done_after_last_wr", {31'd0, done_wr_overlap}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/y86_iram_loader.md
Name: y86_iram_loader

Overview:
- Byte-stream writer that fills the y86 instruction RAM before execution.
- The CPU's fetch path is the reader of the IRAM; this block is the writer on the other port.
- Parses a framed image (sync, base address, length, payload, optional checksum) and issues byte writes to the IRAM write port.
- Holds the CPU in reset (cpu_hold) until a complete, valid image is loaded.

Parameters:
- ADDR_W, 32, width of IRAM byte address and header fields
- MEM_BYTES, 4096, IRAM capacity in bytes; highest legal address is MEM_BYTES-1
- SYNC_BYTE, 8'h86, frame start marker

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte; transfer occurs when in_valid && in_ready
- rearm  in  1  pulse; DONE/ERROR -> IDLE
- wr_en  out  1  IRAM byte write strobe
- wr_addr  out  ADDR_W  IRAM byte address
- wr_data  out  8  IRAM write byte
- cpu_hold  out  1  high keeps CPU in reset
- done  out  1  image loaded
- error  out  1  frame rejected
- bytes_written  out  ADDR_W  payload bytes written this frame

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE; in_ready=1; wr_en=0; wr_addr=0; wr_data=0.
  - cpu_hold=1; done=0; error=0; bytes_written=0.
  - Reset mid-frame discards all progress; bytes already written stay in the IRAM.
- States: IDLE, ADDR, LEN, PAYLOAD, CSUM, DONE, ERROR. All transitions are on accepted bytes only.
- IDLE:
  - Bytes other than SYNC_BYTE are discarded.
  - SYNC_BYTE -> ADDR; header byte counter cleared.
- ADDR: 4 bytes, little-endian, assemble base. After the 4th byte -> LEN.
- LEN: 4 bytes, little-endian, assemble len. After the 4th byte, in this order:
  - len > MEM_BYTES, or base+len > MEM_BYTES (computed at ADDR_W+1 bits, no wrap) -> ERROR.
  - Else len==0 -> CSUM if the checksum feature is compiled in, otherwise DONE.
  - Else -> PAYLOAD.
- PAYLOAD:
  - A byte accepted at edge t produces wr_en=1 for exactly one cycle after edge t+1, with wr_addr=base+idx and wr_data=byte; idx then increments.
  - Back-to-back accepts give back-to-back writes. Latency is 1 cycle; throughput is 1 byte/clk.
  - bytes_written increments together with each wr_en.
  - After byte len-1 is accepted -> CSUM or DONE.
- DONE:
  - in_ready=0; done=1; cpu_hold=0.
  - done and the cpu_hold deassertion appear no earlier than the cycle after the final wr_en.
- ERROR:
  - in_ready=0; error=1; cpu_hold=1; no further writes.
- rearm:
  - Honoured only in DONE/ERROR. Next state is IDLE; done=0, error=0, cpu_hold=1, bytes_written=0.
  - Ignored in all other states.
- in_ready is 1 in IDLE..CSUM.
- in_valid while in_ready=0: byte not consumed, no state change.

Optional Feature:
- Macro Y86_LOADER_CHECKSUM_EN.
- Defined:
  - After the payload, one CSUM byte is expected.
  - The running 8-bit sum (mod 256) of all payload bytes, plus the CSUM byte, must equal 8'h00. Match -> DONE; mismatch -> ERROR.
  - Payload writes are not rolled back on mismatch.
- Undefined:
  - No CSUM state; payload end -> DONE directly.

Decomposition:
- Shared package y86_loader_pkg:
  - State enum.
  - SYNC_BYTE default.
  - Header field byte count (4).
- One natural sub-module, y86_loader_hdr_shift: 4-byte little-endian shift assembler reused for the ADDR and LEN fields. The remainder stays in the top FSM.

Test Plan:
- Stream 86,00,01,00,00,03,00,00,00,30,F0,0A (continuous valid) -> wr_en at addrs 0x100,0x101,0x102 with data 30,F0,0A on consecutive cycles; then done=1, cpu_hold=0, bytes_written=3.
- Garbage 11,22 before 86 plus a 1-byte frame at base 0 -> garbage ignored, single write addr 0, done=1.
- Header base=0xFFE, len=4 with MEM_BYTES=4096 -> error=1 after the 4th LEN byte, zero writes, cpu_hold stays 1.
- in_valid toggling every other cycle during payload -> writes occur only for accepted bytes, addresses contiguous.
- Assert reset low mid-payload, then send a fresh frame -> all outputs at reset values; new frame loads correctly.
- Checksum feature (macro defined): payload 01,02, CSUM FD -> done=1; CSUM FE -> error=1, then rearm -> IDLE with error=0.
